norm2_sqsum_window: RTL and testbench

Cross-channel sum-of-squares stage directly upstream of the norm2 LRN scaling multiplier. Accepts one activation per cycle, channel-major per pixel, and keeps a running sum of squares over a centred window of WIN channels. Emits the window sum, zero-extended to the multiplier's 43-bit signed operand width, together with the matching centre activation for the later divide stage. Edge channels are zero-padded, and every pixel's channel vector is processed independently.

---
 rtl/norm2_sqsum_window_if.sv | 27 ++
 rtl/norm2_sqsum_window.sv | 146 ++++++++++++++
 tb/tb_norm2_sqsum_window.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/norm2_sqsum_window_if.sv
// Stream interface for norm2_sqsum_window: activation input stream,
// window-sum output stream and the sticky consistency flag.
interface norm2_sqsum_window_if #(
  parameter int DATA_W = 16,
  parameter int SUM_W  = 43
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_x;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [SUM_W-1:0]         out_sum;
  logic signed [DATA_W-1:0] out_x;
  logic                     out_last;
  logic                     sum_err;

  modport master (
    output in_valid, in_x, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_x, out_last, sum_err
  );

  modport slave (
    input  in_valid, in_x, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_x, out_last, sum_err
  );
endinterface

// File: rtl/norm2_sqsum_window.sv
// Cross-channel sum-of-squares over a centred window of WIN channels,
// feeding the norm2 LRN scaling multiplier. Edge channels are zero-padded
// by flushing HALF zero samples after each vector's last channel.
// Optional macro NORM2_SQSUM_CHECK_EN adds a shadow adder that re-sums the
// window every cycle and raises sticky sum_err on disagreement with S.
module norm2_sqsum_window #(
  parameter int DATA_W = 16,
  parameter int WIN    = 5,
  parameter int SUM_W  = 43
) (
  input  logic ap_clk,
  input  logic ap_rst,
  norm2_sqsum_window_if.slave bus
);
  localparam int HALF = (WIN - 1) / 2;
  localparam int SQ_W = 2 * DATA_W;
  localparam int KW   = $clog2(HALF + 2);
  localparam int FW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [KW-1:0] K_MAX  = KW'(HALF + 1);
  localparam logic [FW-1:0] F_LAST = FW'(HALF - 1);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

  state_t                   r_state;
  logic [SQ_W-1:0]          r_sq [WIN];
  // Activations of the last HALF shifts; together with the incoming sample
  // this spans the HALF+1 positions needed to pick the centre activation.
  logic signed [DATA_W-1:0] r_xd [HALF];
  logic [SUM_W-1:0]         r_sum;
  logic [KW-1:0]            r_k;
  logic [FW-1:0]            r_f;

  logic                     r_out_valid;
  logic [SUM_W-1:0]         r_out_sum;
  logic signed [DATA_W-1:0] r_out_x;
  logic                     r_out_last;

  logic                     w_adv;
  logic                     w_in_shift;
  logic                     w_fl_shift;
  logic                     w_shift;
  logic                     w_fl_last;
  logic                     w_produce;
  logic signed [SQ_W-1:0]   w_prod;
  logic [SQ_W-1:0]          w_sq_new;
  logic signed [DATA_W-1:0] w_x_new;
  logic [KW-1:0]            w_k_inc;
  logic [SUM_W-1:0]         w_sum_nxt;

  // Shift control: one shift per cycle, either a new sample or a zero flush.
  always_comb begin
    w_adv      = !r_out_valid || bus.out_ready;
    w_in_shift = bus.in_valid && bus.in_ready;
    w_fl_shift = w_adv && (r_state == S_FLUSH);
    w_shift    = w_in_shift || w_fl_shift;
    w_fl_last  = w_fl_shift && (r_f == F_LAST);
    w_prod     = bus.in_x * bus.in_x;
    w_sq_new   = w_in_shift ? $unsigned(w_prod) : '0;
    w_x_new    = w_in_shift ? bus.in_x : '0;
    w_k_inc    = (r_k == K_MAX) ? r_k : r_k + 1'b1;
    w_produce  = w_shift && (w_k_inc == K_MAX);
    w_sum_nxt  = r_sum + SUM_W'(w_sq_new) - SUM_W'(r_sq[WIN-1]);
  end

  assign bus.in_ready  = w_adv && (r_state != S_FLUSH) && !ap_rst;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_x     = r_out_x;
  assign bus.out_last  = r_out_last;

  // Window FSM, running sum and registered output stage.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state     <= S_FILL;
      r_sq        <= '{default: '0};
      r_xd        <= '{default: '0};
      r_sum       <= '0;
      r_k         <= '0;
      r_f         <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_x     <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_shift) begin
        if (w_fl_last) begin
          // Vector done: drop the window so the next vector starts clean.
          r_state <= S_FILL;
          r_sq    <= '{default: '0};
          r_xd    <= '{default: '0};
          r_sum   <= '0;
          r_k     <= '0;
          r_f     <= '0;
        end else begin
          for (int i = WIN - 1; i > 0; i--) r_sq[i] <= r_sq[i-1];
          r_sq[0] <= w_sq_new;
          for (int i = HALF - 1; i > 0; i--) r_xd[i] <= r_xd[i-1];
          r_xd[0] <= w_x_new;
          r_sum   <= w_sum_nxt;
          r_k     <= w_k_inc;
          case (r_state)
            S_FILL, S_RUN: begin
              if (bus.in_last) begin
                r_state <= S_FLUSH;
                r_f     <= '0;
              end else if (w_k_inc == K_MAX) begin
                r_state <= S_RUN;
              end
            end
            S_FLUSH: r_f <= r_f + 1'b1;
            default: r_state <= S_FILL;
          endcase
        end
      end
      if (w_produce) begin
        r_out_valid <= 1'b1;
        r_out_sum   <= w_sum_nxt;
        r_out_x     <= r_xd[HALF-1];
        r_out_last  <= w_fl_last;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef NORM2_SQSUM_CHECK_EN
  logic [SUM_W-1:0] w_shadow;
  logic             r_err;

  // Independent re-sum of the window contents.
  always_comb begin
    w_shadow = '0;
    for (int i = 0; i < WIN; i++) w_shadow = w_shadow + SUM_W'(r_sq[i]);
  end

  // Sticky flag: any drift between running and shadow sum.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) r_err <= 1'b0;
    else if (w_shadow != r_sum) r_err <= 1'b1;
  end

  assign bus.sum_err = r_err;
`else
  assign bus.sum_err = 1'b0;
`endif
endmodule

// File: tb/tb_norm2_sqsum_window.sv
// Directed plus randomized bench for norm2_sqsum_window. Expected outputs
// come from a direct per-channel window sum over each vector.
module tb_norm2_sqsum_window;
  localparam int DATA_W = 16;
  localparam int WIN    = 5;
  localparam int SUM_W  = 43;
  localparam int HALF   = (WIN - 1) / 2;

  typedef struct {
    longint            sum;
    logic [DATA_W-1:0] x;
    logic              last;
  } exp_t;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  norm2_sqsum_window_if #(.DATA_W(DATA_W), .SUM_W(SUM_W)) bus ();

  norm2_sqsum_window #(.DATA_W(DATA_W), .WIN(WIN), .SUM_W(SUM_W)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  exp_t q[$];
  int   vec[$];
  int   checks   = 0;
  int   errors   = 0;
  int   rdy_mode = 0;
  int   hs_total = 0;
  int   hs_base  = 0;
  int   hold     = 0;
  bit   rnd_in   = 0;

  // Downstream ready pattern: 0 always, 1 random, 2 three-cycle stall after 2nd output.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge ap_clk); #1;
      case (rdy_mode)
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        2: if (hs_total - hs_base == 2 && hold < 3) begin
             bus.out_ready = 1'b0;
             hold++;
           end else bus.out_ready = 1'b1;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: scoreboard compare on handshake, stability check on stall.
  logic              pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [SUM_W-1:0]  ps = '0;
  logic [DATA_W-1:0] px = '0;
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        checks++;
        assert (bus.out_valid === 1'b1 && bus.out_sum === ps && bus.out_x === px && bus.out_last === pl)
        else begin
          errors++;
          $error("FAIL hold: valid=%b sum=%0d x=%0d last=%b required valid=1 sum=%0d x=%0d last=%b",
                 bus.out_valid, bus.out_sum, bus.out_x, bus.out_last, ps, $signed(px), pl);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_total++;
        checks++;
        assert (q.size() > 0)
        else begin
          errors++;
          $error("FAIL extra_out: got sum=%0d x=%0d with no output expected", bus.out_sum, bus.out_x);
        end
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          checks++;
          assert (longint'(bus.out_sum) === e.sum && bus.out_x === e.x && bus.out_last === e.last)
          else begin
            errors++;
            $error("FAIL out: sum=%0d x=%0d last=%b required sum=%0d x=%0d last=%b",
                   bus.out_sum, bus.out_x, bus.out_last, e.sum, $signed(e.x), e.last);
          end
        end
      end
      pv = bus.out_valid; pr = bus.out_ready;
      ps = bus.out_sum;   px = bus.out_x;   pl = bus.out_last;
    end
  end

  // Reference: zero-padded centred window sum per channel.
  task automatic push_model();
    int c;
    c = vec.size();
    for (int i = 0; i < c; i++) begin
      exp_t e;
      e.sum = 0;
      for (int j = i - HALF; j <= i + HALF; j++)
        if (j >= 0 && j < c) e.sum += longint'(vec[j]) * longint'(vec[j]);
      e.x    = DATA_W'(vec[i]);
      e.last = (i == c - 1);
      q.push_back(e);
    end
  endtask

  // Drive vec; returns #1 after the accepting edge of the last sample.
  task automatic send_vec();
    int n;
    for (int i = 0; i < vec.size(); i++) begin
      if (rnd_in)
        while ($urandom_range(0, 3) == 0) begin
          bus.in_valid = 1'b0;
          @(posedge ap_clk); #1;
        end
      bus.in_valid = 1'b1;
      bus.in_x     = DATA_W'(vec[i]);
      bus.in_last  = (i == vec.size() - 1);
      n = 0;
      do begin @(negedge ap_clk); n++; end while (!bus.in_ready && n < 1000);
      if (!bus.in_ready) begin
        checks++; errors++;
        $error("FAIL accept_timeout: in_ready=%b required 1 within 1000 cycles", bus.in_ready);
      end
      @(posedge ap_clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 5000) begin @(posedge ap_clk); n++; end
    @(posedge ap_clk); #1;
    checks++;
    assert (q.size() == 0)
    else begin
      errors++;
      $error("FAIL drain: %0d outputs outstanding, required 0", q.size());
    end
  endtask

  task automatic chk_ready(input logic exp, input int step);
    checks++;
    assert (bus.in_ready === exp)
    else begin
      errors++;
      $error("FAIL gap_ready[%0d]: in_ready=%b required %b", step, bus.in_ready, exp);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    bus.in_last  = 1'b0;
    ap_rst       = 1'b1;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    checks++;
    assert (bus.out_valid === 1'b0) else begin errors++; $error("FAIL rst_valid: %b required 0", bus.out_valid); end
    checks++;
    assert (bus.out_sum === '0) else begin errors++; $error("FAIL rst_sum: %0d required 0", bus.out_sum); end
    checks++;
    assert (bus.out_x === '0) else begin errors++; $error("FAIL rst_x: %0d required 0", bus.out_x); end
    checks++;
    assert (bus.out_last === 1'b0) else begin errors++; $error("FAIL rst_last: %b required 0", bus.out_last); end
    checks++;
    assert (bus.sum_err === 1'b0) else begin errors++; $error("FAIL rst_err: %b required 0", bus.sum_err); end
    checks++;
    assert (bus.in_ready === 1'b0) else begin errors++; $error("FAIL rst_ready: %b required 0", bus.in_ready); end
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;

    // Basic vector: 14,30,55,54,50.
    vec = '{1, 2, 3, 4, 5};
    push_model(); send_vec(); wait_drain();

    // Single channel at the negative extreme, then the HALF-cycle gap.
    vec = '{-32768};
    push_model(); send_vec();
    chk_ready(1'b0, 0);
    @(posedge ap_clk); #1;
    chk_ready(1'b0, 1);
    @(posedge ap_clk); #1;
    chk_ready(1'b1, 2);
    wait_drain();

    // Back-to-back vectors, no carry-over.
    vec = '{3, 0, 4};
    push_model(); send_vec();
    vec = '{1, 1};
    push_model(); send_vec(); wait_drain();

    // Downstream stall after the 2nd output.
    hs_base  = hs_total;
    hold     = 0;
    rdy_mode = 2;
    vec = '{1, 2, 3, 4, 5};
    push_model(); send_vec(); wait_drain();
    rdy_mode = 0;

    // Reset during FLUSH abandons the remaining outputs.
    vec = '{1, 2, 3, 4, 5};
    push_model(); send_vec();
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    q.delete();
    @(negedge ap_clk);
    checks++;
    assert (bus.out_valid === 1'b0)
    else begin errors++; $error("FAIL flush_rst_valid: %b required 0", bus.out_valid); end
    @(posedge ap_clk); #1;
    vec = '{2};
    push_model(); send_vec(); wait_drain();

    // Randomized vectors with input gaps and output stalls.
    rnd_in   = 1;
    rdy_mode = 1;
    for (int v = 0; v < 400; v++) begin
      int c;
      c = $urandom_range(1, 64);
      vec.delete();
      for (int i = 0; i < c; i++)
        vec.push_back(($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768);
      push_model(); send_vec();
    end
    wait_drain();
    rdy_mode = 0;
    rnd_in   = 0;

    checks++;
    assert (bus.sum_err === 1'b0)
    else begin errors++; $error("FAIL sum_err: %b required 0", bus.sum_err); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
